clock_divider: RTL and testbench
================================

CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of the clk_div input and the internal counter.
REQ-002 Port: src_clk  input  1  source clock; sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of src_clk.
REQ-004 Port: clk_div  input  WIDTH  half-period of clock_out in src_clk cycles; unsigned.
REQ-005 Port: clock_out  output  1  divided clock, driven directly from a flop (glitch-free).

Function
REQ-006 Internal state SHALL be a WIDTH-bit counter cnt and the clock_out flop; no other state.
REQ-007 With reset=1 and clk_div=0, each rising edge SHALL set cnt=0 and clock_out=0 (divider disabled, output held low).
REQ-008 With reset=1 and clk_div>=1, if cnt+1 >= clk_div, the edge SHALL clear cnt to 0 and invert clock_out.
REQ-009 With reset=1 and clk_div>=1, if cnt+1 < clk_div, the edge SHALL increment cnt by 1 and hold clock_out.
REQ-010 The cnt+1 comparison SHALL be evaluated at WIDTH+1 bits so that cnt=2^WIDTH-1 never wraps.
REQ-011 Steady state: clock_out SHALL have a period of 2*clk_div src_clk cycles at exactly 50% duty cycle.
REQ-012 clk_div=1 SHALL make clock_out toggle on every src_clk edge, giving src_clk/2.
REQ-013 clk_div is sampled every cycle with no shadow register; a new value takes effect on the next edge.
REQ-014 Lowering clk_div mid-period to a value <= cnt+1 SHALL toggle on the next edge; using >= rather than == prevents a 2^WIDTH-cycle overrun.
REQ-015 Raising clk_div mid-period SHALL extend the current half-period; cnt continues counting without reset.
REQ-016 X/Z on clk_div is out of scope; no combinational path from any input to clock_out.

Reset
REQ-017 reset=0 at a rising edge SHALL force cnt=0 and clock_out=0 on that edge, overriding REQ-007..REQ-009.
REQ-018 At the first edge with reset=1 and clk_div=N>=1, the divider SHALL begin counting from cnt=0; the first rising edge of clock_out follows N src_clk edges after reset release.
REQ-019 Reset asserted mid-period SHALL abort the period immediately: clock_out low, cnt=0 on that edge.
REQ-020 Power-up values before the first reset are don't-care.

Structure
REQ-021 Package clock_divider_pkg SHALL hold the default WIDTH constant (32) and the counter typedef; no other shared items.
REQ-022 Counter and compare logic MAY be a sub-module clk_div_counter (ports: clk, reset, limit, cnt, wrap); the toggle flop lives in clock_divider.
REQ-023 clock_out SHALL NOT be used as a clock inside this block.

Verification (src_clk period 10 ns)
REQ-024 reset=0 for 100 ns with clk_div=0, then reset=1 and clk_div=1 -> clock_out low during reset, then toggles every edge (period 20 ns).
REQ-025 clk_div=6 steady -> clock_out high 60 ns and low 60 ns (period 120 ns), 50% duty.
REQ-026 clk_div stepped +5 every 500 ns starting from 1 (1, 6, 11, 16, ...) -> each new half-period equals the new value; no missing toggle and no overrun.
REQ-027 clk_div=11 with cnt=9, then clk_div changed to 6 -> toggle on the next edge, then 6-cycle half-periods.
REQ-028 clk_div=0 after running -> clock_out forced low on the next edge and held low; clk_div=3 afterwards -> first rise 3 edges later.
REQ-029 reset=0 pulsed for one cycle while clock_out=1 at cnt=4 (clk_div=8) -> clock_out=0 and cnt=0 on that edge; restarts per REQ-018.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// ---------------------------------------------------------------------------
// clock_divider_pkg
//   Shared definitions for the clock divider block.
//   DEFAULT_WIDTH : default bit width of the half-period input and counter.
//   cnt_t         : counter type at the default width.
// ---------------------------------------------------------------------------
package clock_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

endpackage : clock_divider_pkg

// File: rtl/clk_div_counter.sv
// ---------------------------------------------------------------------------
// clk_div_counter
//   Half-period counter for the clock divider. Counts src_clk edges since the
//   last output toggle and flags the edge on which the output must toggle.
//
// Ports
//   clk    in   clock (all state on rising edge)
//   reset  in   synchronous active-low reset
//   limit  in   half-period length in clk cycles; 0 disables counting
//   cnt    out  current counter value
//   wrap   out  high when the coming edge ends the half-period
// ---------------------------------------------------------------------------
module clk_div_counter
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH:0]   cnt_plus_one;
  logic             enabled;

  // One extra bit so that cnt = all-ones compares as 2^WIDTH instead of
  // wrapping to zero and missing the toggle.
  assign cnt_plus_one = {1'b0, cnt_reg} + {{WIDTH{1'b0}}, 1'b1};
  assign enabled      = (limit != '0);

  // ">=" rather than "==" so that lowering limit below the running count
  // ends the half-period on the next edge instead of counting all the way
  // around the counter range.
  assign wrap = enabled && (cnt_plus_one >= {1'b0, limit});

  always_comb begin
    cnt_next = cnt_reg;
    if (!enabled || wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_plus_one[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule : clk_div_counter

// File: rtl/clock_divider.sv
// ---------------------------------------------------------------------------
// clock_divider
//   Programmable clock divider. clock_out is a 50% duty-cycle clock with a
//   period of 2*clk_div src_clk cycles; clk_div = 0 holds the output low.
//   clk_div is used live every cycle, so a new value acts on the next edge.
//
// Ports
//   src_clk    in   source clock, sole clock of the block
//   reset      in   synchronous active-low reset
//   clk_div    in   half-period of clock_out in src_clk cycles (unsigned)
//   clock_out  out  divided clock, straight from a flop
// ---------------------------------------------------------------------------
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             src_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] clk_div,
  output logic             clock_out
);

  logic [WIDTH-1:0] cnt_value;
  logic             wrap;
  logic             clock_out_reg;
  logic             clock_out_next;
  logic             unused_cnt;

  clk_div_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (src_clk),
    .reset (reset),
    .limit (clk_div),
    .cnt   (cnt_value),
    .wrap  (wrap)
  );

  // The count itself is only needed inside the counter; it stays on the
  // hierarchy for observation when debugging.
  assign unused_cnt = ^cnt_value;

  always_comb begin
    clock_out_next = clock_out_reg;
    if (clk_div == '0) begin
      clock_out_next = 1'b0;
    end else if (wrap) begin
      clock_out_next = ~clock_out_reg;
    end
  end

  always_ff @(posedge src_clk) begin
    if (!reset) begin
      clock_out_reg <= 1'b0;
    end else begin
      clock_out_reg <= clock_out_next;
    end
  end

  assign clock_out = clock_out_reg;

endmodule : clock_divider

// File: tb/tb_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_clock_divider
//   Directed bench for clock_divider. Inputs change 1 ns after a rising
//   edge; clock_out is sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_clock_divider;

  localparam int WIDTH = 32;

  logic             src_clk;
  logic             reset;
  logic [WIDTH-1:0] clk_div;
  logic             clock_out;

  int n_compared;
  int n_mismatched;

  clock_divider #(
    .WIDTH (WIDTH)
  ) dut (
    .src_clk   (src_clk),
    .reset     (reset),
    .clk_div   (clk_div),
    .clock_out (clock_out)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    clk_div = '0;
    tick();
    tick();
  endtask

  // reset low with clk_div = 0 for 100 ns: output held low throughout.
  task automatic test_reset();
    reset   = 1'b0;
    clk_div = '0;
    $display("test_reset: reset=0 clk_div=0 for 10 cycles");
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_hold edge %0d: clock_out=%b expected 0", i, clock_out);
      end
    end
  endtask

  // Release with clk_div = 1: toggles every edge, first edge goes high.
  task automatic test_div1();
    reset   = 1'b1;
    clk_div = 1;
    $display("test_div1: reset=1 clk_div=1");
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'(i % 2)) begin
        n_mismatched++;
        $display("FAIL div1 edge %0d: clock_out=%b expected %0d", i, clock_out, i % 2);
      end
    end
  endtask

  // clk_div = 6: first rise on edge 6, then 6 high / 6 low.
  task automatic test_div6();
    apply_reset();
    reset   = 1'b1;
    clk_div = 6;
    $display("test_div6: reset=1 clk_div=6");
    for (int k = 1; k <= 36; k++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'((k / 6) % 2)) begin
        n_mismatched++;
        $display("FAIL div6 edge %0d: clock_out=%b expected %0d", k, clock_out, (k / 6) % 2);
      end
    end
  endtask

  // clk_div = 1, 6, 11, 16 for 50 cycles each: every half-period equals the
  // value in force on its closing edge, and no half-period overruns it.
  task automatic test_step();
    int run_len;
    int toggles;
    int cur;
    logic prev;
    apply_reset();
    reset   = 1'b1;
    run_len = 0;
    toggles = 0;
    prev    = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      cur     = (cyc / 50) * 5 + 1;
      clk_div = cur;
      if (cyc % 50 == 0) $display("test_step: clk_div=%0d at cycle %0d", cur, cyc);
      tick();
      run_len++;
      n_compared++;
      if (clock_out !== prev) begin
        if (run_len != cur) begin
          n_mismatched++;
          $display("FAIL step_half cycle %0d: half-period=%0d expected %0d", cyc, run_len, cur);
        end
        toggles++;
        run_len = 0;
        prev    = clock_out;
      end else if (run_len >= cur) begin
        n_mismatched++;
        $display("FAIL step_overrun cycle %0d: no toggle after %0d edges, expected toggle at %0d", cyc, run_len, cur);
      end
    end
    n_compared++;
    if (toggles != 65) begin
      n_mismatched++;
      $display("FAIL step_toggles: counted %0d expected 65", toggles);
    end
  endtask

  // clk_div = 11 until cnt = 9, then 6: toggle on the next edge, then
  // 6-cycle half-periods.
  task automatic test_lower();
    int exp;
    apply_reset();
    reset   = 1'b1;
    clk_div = 11;
    $display("test_lower: clk_div=11 for 9 cycles");
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'b0) begin
        n_mismatched++;
        $display("FAIL lower_pre edge %0d: clock_out=%b expected 0", k, clock_out);
      end
    end
    clk_div = 6;
    $display("test_lower: clk_div=6 with cnt=9");
    for (int j = 1; j <= 14; j++) begin
      tick();
      exp = (((j - 1) / 6) % 2 == 0) ? 1 : 0;
      n_compared++;
      if (clock_out !== 1'(exp)) begin
        n_mismatched++;
        $display("FAIL lower_post edge %0d: clock_out=%b expected %0d", j, clock_out, exp);
      end
    end
  endtask

  // clk_div = 0 while high: low on next edge and held; then clk_div = 3
  // rises 3 edges later.
  task automatic test_zero();
    apply_reset();
    reset   = 1'b1;
    clk_div = 3;
    $display("test_zero: clk_div=3 for 4 cycles");
    repeat (4) tick();
    n_compared++;
    if (clock_out !== 1'b1) begin
      n_mismatched++;
      $display("FAIL zero_running: clock_out=%b expected 1", clock_out);
    end
    clk_div = 0;
    $display("test_zero: clk_div=0");
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'b0) begin
        n_mismatched++;
        $display("FAIL zero_hold edge %0d: clock_out=%b expected 0", k, clock_out);
      end
    end
    clk_div = 3;
    $display("test_zero: clk_div=3 restart");
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'(k / 3 % 2)) begin
        n_mismatched++;
        $display("FAIL zero_restart edge %0d: clock_out=%b expected %0d", k, clock_out, k / 3 % 2);
      end
    end
  endtask

  // clk_div = 8, one-cycle reset at cnt = 4 while high: low at once, then
  // first rise 8 edges after release.
  task automatic test_reset_mid();
    apply_reset();
    reset   = 1'b1;
    clk_div = 8;
    $display("test_reset_mid: clk_div=8 for 12 cycles");
    repeat (12) tick();
    n_compared++;
    if (clock_out !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_mid_pre: clock_out=%b expected 1", clock_out);
    end
    reset = 1'b0;
    $display("test_reset_mid: reset=0 pulse");
    tick();
    n_compared++;
    if (clock_out !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_mid_pulse: clock_out=%b expected 0", clock_out);
    end
    reset = 1'b1;
    $display("test_reset_mid: reset=1 restart");
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_compared++;
      if (clock_out !== 1'(k / 8 % 2)) begin
        n_mismatched++;
        $display("FAIL reset_mid_restart edge %0d: clock_out=%b expected %0d", k, clock_out, k / 8 % 2);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b0;
    clk_div      = '0;
    test_reset();
    test_div1();
    test_div6();
    test_step();
    test_lower();
    test_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_clock_divider
